// File: rtl/ar_outgoing_request_buffer_if.sv
// AR request bundle between the ID-ordering stage, the outgoing
// buffer and the slave-side AR channel.
interface ar_if #(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender (
        output valid, id, addr, len, size, burst, qos,
        input  ready
    );

    modport receiver (
        input  valid, id, addr, len, size, burst, qos,
        output ready
    );
endinterface

// File: rtl/ar_outgoing_request_buffer.sv
// In-order AR FIFO toward the slave; no fall-through, explicit pointer wrap.
// AR_OUTBUF_FULL_PASS_EN: accept a push while full when a pop happens too.
module ar_outgoing_request_buffer #(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    ar_if.receiver                     ar_in,
    ar_if.sender                       ar_out,
    output logic                       Outcoming_buffer_full,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [LEN_WIDTH-1:0]   len;
        logic [SIZE_WIDTH-1:0]  size;
        logic [BURST_WIDTH-1:0] burst;
        logic [QOS_WIDTH-1:0]   qos;
    } ar_req_t;

    ar_req_t        mem_q [DEPTH];
    ar_req_t        wr_d;
    ar_req_t        rd;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic           full;
    logic           push;
    logic           pop;

    assign full = (occ_q == OW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Payload storage carries no reset; valid gates its visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_d;
    end

    always_comb begin
        wr_d.id    = ar_in.id;
        wr_d.addr  = ar_in.addr;
        wr_d.len   = ar_in.len;
        wr_d.size  = ar_in.size;
        wr_d.burst = ar_in.burst;
        wr_d.qos   = ar_in.qos;
        push = ar_in.valid & ar_in.ready;
        pop  = ar_out.valid & ar_out.ready;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        // Explicit wrap keeps non power-of-two depths correct.
        if (push)
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        rd = mem_q[rptr_q];
`ifdef AR_OUTBUF_FULL_PASS_EN
        ar_in.ready = ~full | ar_out.ready;
`else
        ar_in.ready = ~full;
`endif
        ar_out.valid = (occ_q != '0);
        ar_out.id    = rd.id;
        ar_out.addr  = rd.addr;
        ar_out.len   = rd.len;
        ar_out.size  = rd.size;
        ar_out.burst = rd.burst;
        ar_out.qos   = rd.qos;
        Outcoming_buffer_full = full;
        occupancy = occ_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef AR_OUTBUF_FULL_PASS_EN
            assert (!(push && !pop && full));
`else
            assert (!(push && full));
`endif
            assert (!(pop && occ_q == '0));
        end
    end
endmodule

// File: tb/tb_ar_outgoing_request_buffer.sv
// Directed bench: DEPTH=4 instance for the main plan, DEPTH=3 for wrap.
module tb_ar_outgoing_request_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    ar_if ai ();
    ar_if ao ();
    logic       a_full;
    logic [2:0] a_occ;

    ar_if bi ();
    ar_if bo ();
    logic       b_full;
    logic [1:0] b_occ;

    ar_outgoing_request_buffer #(.DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .ar_in(ai), .ar_out(ao),
        .Outcoming_buffer_full(a_full), .occupancy(a_occ)
    );

    ar_outgoing_request_buffer #(.DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .ar_in(bi), .ar_out(bo),
        .Outcoming_buffer_full(b_full), .occupancy(b_occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int id);
        ai.valid = 1'b1;
        ai.id    = 4'(id);
        ai.addr  = 32'(id * 16);
        step();
        ai.valid = 1'b0;
    endtask

    int exp4 [4];
    int next_in;
    int next_out;
    int cyc;
    logic pushed;

    initial begin
        ai.valid = 0; ai.id = 0; ai.addr = 0; ai.len = 0;
        ai.size = 0; ai.burst = 0; ai.qos = 0; ao.ready = 0;
        bi.valid = 0; bi.id = 0; bi.addr = 0; bi.len = 0;
        bi.size = 0; bi.burst = 0; bi.qos = 0; bo.ready = 0;

        // 1: reset
        repeat (3) step();
        chk("rst_valid_low", 64'(ao.valid), 64'd0);
        rst = 1'b1;
        step();
        chk("rst_valid", 64'(ao.valid), 64'd0);
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_full", 64'(a_full), 64'd0);
        chk("rst_ready", 64'(ai.ready), 64'd1);
        chk("rst_b_occ", 64'(b_occ), 64'd0);

        // 2: single pass-through
        ao.ready = 1'b1;
        ai.valid = 1'b1; ai.id = 4'd3; ai.addr = 32'h1000;
        ai.len = 8'd7; ai.size = 3'd2; ai.burst = 2'd1; ai.qos = 4'd5;
        chk("t2_no_bypass", 64'(ao.valid), 64'd0);
        step();
        ai.valid = 1'b0;
        chk("t2_valid", 64'(ao.valid), 64'd1);
        chk("t2_id", 64'(ao.id), 64'd3);
        chk("t2_addr", 64'(ao.addr), 64'h1000);
        chk("t2_len", 64'(ao.len), 64'd7);
        chk("t2_size", 64'(ao.size), 64'd2);
        chk("t2_burst", 64'(ao.burst), 64'd1);
        chk("t2_qos", 64'(ao.qos), 64'd5);
        chk("t2_occ1", 64'(a_occ), 64'd1);
        step();
        chk("t2_occ0", 64'(a_occ), 64'd0);
        chk("t2_valid0", 64'(ao.valid), 64'd0);

        // 3: fill, hold 5th, drain in order
        ao.ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_a(i);
        chk("t3_full", 64'(a_full), 64'd1);
        chk("t3_ready", 64'(ai.ready), 64'd0);
        chk("t3_occ", 64'(a_occ), 64'd4);
        ai.valid = 1'b1; ai.id = 4'd5;
        step();
        ai.valid = 1'b0;
        chk("t3_held", 64'(a_occ), 64'd4);
        ao.ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain_valid", 64'(ao.valid), 64'd1);
            chk("t3_drain_id", 64'(ao.id), 64'(i));
            chk("t3_drain_addr", 64'(ao.addr), 64'(i * 16));
            step();
        end
        chk("t3_empty", 64'(a_occ), 64'd0);
        chk("t3_ready1", 64'(ai.ready), 64'd1);

        // 4: push and pop together while full
        ao.ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_a(i);
        ai.valid = 1'b1; ai.id = 4'd9; ai.addr = 32'(9 * 16);
        ao.ready = 1'b1;
`ifdef AR_OUTBUF_FULL_PASS_EN
        chk("t4_ready_pass", 64'(ai.ready), 64'd1);
        step();
        ai.valid = 1'b0; ao.ready = 1'b0;
        chk("t4_occ_pass", 64'(a_occ), 64'd4);
        chk("t4_full_pass", 64'(a_full), 64'd1);
`else
        chk("t4_ready_blk", 64'(ai.ready), 64'd0);
        step();
        ao.ready = 1'b0;
        chk("t4_occ3", 64'(a_occ), 64'd3);
        chk("t4_ready_again", 64'(ai.ready), 64'd1);
        step();
        ai.valid = 1'b0;
        chk("t4_occ4", 64'(a_occ), 64'd4);
`endif
        exp4 = '{2, 3, 4, 9};
        ao.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_id", 64'(ao.id), 64'(exp4[i]));
            step();
        end
        chk("t4_empty", 64'(a_occ), 64'd0);
        ao.ready = 1'b0;

        // 5: DEPTH=3 with random stalls, ids 0..9
        next_in = 0;
        next_out = 0;
        cyc = 0;
        while (next_out < 10 && cyc < 400) begin
            bi.valid = (next_in < 10) && ($urandom_range(0, 3) != 0);
            bi.id = 4'(next_in);
            bi.addr = 32'(next_in + 32'h100);
            bo.ready = ($urandom_range(0, 2) != 0);
            pushed = bi.valid && bi.ready;
            if (bo.valid && bo.ready) begin
                chk("t5_order", 64'(bo.id), 64'(next_out));
                next_out++;
            end
            step();
            if (pushed) next_in++;
            cyc++;
        end
        bi.valid = 1'b0; bo.ready = 1'b0;
        chk("t5_all_out", 64'(next_out), 64'd10);
        chk("t5_all_in", 64'(next_in), 64'd10);
        chk("t5_empty", 64'(b_occ), 64'd0);

        // 6: async reset with entries stored
        ao.ready = 1'b0;
        push_a(6);
        push_a(7);
        chk("t6_occ2", 64'(a_occ), 64'd2);
        chk("t6_valid", 64'(ao.valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_valid", 64'(ao.valid), 64'd0);
        chk("t6_async_occ", 64'(a_occ), 64'd0);
        chk("t6_async_full", 64'(a_full), 64'd0);
        step();
        rst = 1'b1;
        ao.ready = 1'b1;
        repeat (3) begin
            step();
            chk("t6_no_stale", 64'(ao.valid), 64'd0);
        end
        chk("t6_occ_final", 64'(a_occ), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ar_outgoing_request_buffer.md
Name: ar_outgoing_request_buffer

Overview:
- Synchronous AR FIFO between the AR ID-ordering stage (upstream) and the slave-side AR channel (downstream).
- Stores AR requests that already carry a unique ID. Releases them to the slave in order.
- Exports a full flag, which the ordering stage uses to stop taking new requests.
- No field is changed. ID, addr, len, size, burst and qos pass through unchanged.

Parameters:
- ID_WIDTH, 4, AR ID width (unique ID).
- ADDR_WIDTH, 32, address width.
- LEN_WIDTH, 8, burst length width.
- SIZE_WIDTH, 3, beat size width.
- BURST_WIDTH, 2, burst type width.
- QOS_WIDTH, 4, QoS width.
- DEPTH, 4, number of entries. Legal range 2..256; any integer, power of two not required.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ar_in  ar_if.receiver  bundle  requests from the ordering stage (valid/ready/id/addr/len/size/burst/qos).
- ar_out  ar_if.sender  bundle  requests toward the slave.
- Outcoming_buffer_full  output  1  high when occupancy == DEPTH.
- occupancy  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - Write pointer, read pointer and occupancy go to 0.
  - ar_out.valid=0, Outcoming_buffer_full=0, ar_in.ready=1 (1 also under AR_OUTBUF_FULL_PASS_EN, since full=0).
  - Payload storage is not reset. ar_out payload is don't-care while valid=0.
  - Reset mid-operation discards all stored entries. Nothing is emitted afterward.
- Push and pop:
  - push = ar_in.valid & ar_in.ready. The payload is written at wptr on the clock edge.
  - pop = ar_out.valid & ar_out.ready. rptr advances on the clock edge.
- Ready and valid:
  - ar_in.ready = ~Outcoming_buffer_full. It depends only on registered state, never on ar_out.ready (default build).
  - ar_out.valid = (occupancy != 0).
  - ar_out payload = storage[rptr]. It is held stable while valid & ~ready.
- Latency: no fall-through. An entry pushed at edge N is visible on ar_out from cycle N+1 (1-cycle minimum latency).
- Pointers: each is $clog2(DEPTH) bits wide. Each increments by 1 and wraps from DEPTH-1 to 0 explicitly, so the wrap is also correct when DEPTH is not a power of two.
- Occupancy update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop, or on neither.
  - Outcoming_buffer_full = (occupancy == DEPTH), derived from the registered occupancy.
- Empty: a simultaneous push is legal. Occupancy becomes 1 and ar_out.valid rises the next cycle. No same-cycle bypass.
- Full (default build): push is blocked even if a pop occurs in the same cycle. The next cycle shows occupancy DEPTH-1 and ready=1.
- Ordering: strict FIFO. Entries leave in acceptance order and never drop or duplicate.
- Overflow and underflow are structurally impossible. Assertions must check both:
  - push while occupancy==DEPTH is an error;
  - pop while occupancy==0 is an error.

Optional Feature:
- Macro: AR_OUTBUF_FULL_PASS_EN.
- When defined:
  - ar_in.ready = ~Outcoming_buffer_full | ar_out.ready.
  - When full, a push and a pop in the same cycle are both accepted. Occupancy stays DEPTH and pointers both advance.
  - This creates a combinational path ar_out.ready -> ar_in.ready.
  - Outcoming_buffer_full keeps its meaning (occupancy==DEPTH). The ordering stage may therefore still stall on it.
- When undefined: default behaviour above. No ready path from downstream.

Test Plan:
1. Reset with rst=0 for 3 cycles, then release -> ar_out.valid=0, occupancy=0, full=0, ar_in.ready=1.
2. Push id=3, addr=0x1000, len=7, size=2, burst=1, qos=5 with ar_out.ready=1 -> ar_out.valid=1 one cycle later with identical fields. Pop occurs. occupancy back to 0 the cycle after.
3. DEPTH=4, ar_out.ready=0, push ids 1,2,3,4 -> full=1, ar_in.ready=0 after 4th push. A 5th valid is held and not accepted. Then ready=1 drains ids 1,2,3,4 in order, one per cycle.
4. Full, ar_in.valid=1 and ar_out.ready=1 in the same cycle:
   - default build -> only pop; occupancy 3, then the push is accepted the next cycle;
   - with AR_OUTBUF_FULL_PASS_EN -> both accepted, occupancy stays 4.
5. DEPTH=3, 10 pushes/pops with random ready/valid stalls and ids 0..9 -> pointers wrap 2->0. Output order is 0..9 with no loss or duplication.
6. Occupancy 2, assert rst=0 mid-burst while ar_out.valid=1 -> valid drops immediately (asynchronously). After release, no stale entry is emitted.
